// File: rtl/sort4_seq_ctrl.sv
// Sequential 4-input descending sorter: one compare-exchange unit stepped across a 5-pair network.
// Optional swap counter port is enabled with SORT4_SWAPCNT_EN.
//
// state | meaning
// IDLE  | ready for a new operand set; slots hold the last result
// CMP   | one compare-exchange per cycle, pair chosen by r_step (0..4)
// DONE  | result valid in slots; waits for consumer handshake
module sort4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_ra,
  output logic [WIDTH-1:0] o_rb,
  output logic [WIDTH-1:0] o_rc,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_busy
`ifdef SORT4_SWAPCNT_EN
  ,
  output logic [2:0]       o_swap_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_step;
  logic [WIDTH-1:0] r_slot [4];
  logic [1:0]       w_x;
  logic [1:0]       w_y;
  logic [WIDTH-1:0] w_vx;
  logic [WIDTH-1:0] w_vy;
  logic             w_swap;
  logic             w_load;

  // Network pair schedule: (0,2) (1,3) (0,1) (2,3) (1,2)
  always_comb begin
    w_x = 2'd1;
    w_y = 2'd2;
    case (r_step)
      3'd0: begin w_x = 2'd0; w_y = 2'd2; end
      3'd1: begin w_x = 2'd1; w_y = 2'd3; end
      3'd2: begin w_x = 2'd0; w_y = 2'd1; end
      3'd3: begin w_x = 2'd2; w_y = 2'd3; end
      default: begin w_x = 2'd1; w_y = 2'd2; end
    endcase
  end

  assign w_vx   = r_slot[w_x];
  assign w_vy   = r_slot[w_y];
  assign w_swap = (r_state == S_CMP) && (w_vx < w_vy);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs depend on the registered state only
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        o_busy = 1'b1;
        if (r_step == 3'd4) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= 3'd0;
    end else if (w_load) begin
      r_step <= 3'd0;
    end else if ((r_state == S_CMP) && (r_step != 3'd4)) begin
      r_step <= r_step + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_load) begin
      r_slot[0] <= i_a;
      r_slot[1] <= i_b;
      r_slot[2] <= i_c;
      r_slot[3] <= i_d;
    end else if (w_swap) begin
      r_slot[w_x] <= w_vy;
      r_slot[w_y] <= w_vx;
    end
  end

  assign o_ra = r_slot[0];
  assign o_rb = r_slot[1];
  assign o_rc = r_slot[2];
  assign o_rd = r_slot[3];

`ifdef SORT4_SWAPCNT_EN
  logic [2:0] r_swap_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_swap_cnt <= 3'd0;
    end else if (w_load) begin
      r_swap_cnt <= 3'd0;
    end else if (w_swap) begin
      r_swap_cnt <= r_swap_cnt + 3'd1;
    end
  end

  assign o_swap_cnt = r_swap_cnt;
`endif

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Self-checking bench for sort4_seq_ctrl: behavioural model plus directed and random stimulus.
// Define SORT4_SWAPCNT_EN to also check the swap counter port.
module tb_sort4_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ra, rb, rc, rd;
  logic         busy;
`ifdef SORT4_SWAPCNT_EN
  logic [2:0]   swap_cnt;
`endif

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  sort4_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_ra(ra), .o_rb(rb), .o_rc(rc), .o_rd(rd), .o_busy(busy)
`ifdef SORT4_SWAPCNT_EN
    , .o_swap_cnt(swap_cnt)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 sorting, 2 result held for consumer
  int m_phase = 0;
  int m_cnt = 0;
  int m_hold [4] = '{0, 0, 0, 0};
  int m_res  [4] = '{0, 0, 0, 0};
  int m_ops  [4] = '{0, 0, 0, 0};
  int m_swaps = 0;
  int m_res_sw = 0;
  int n_accepts = 0;
  int cyc = 0;
  int accept_cyc [$];

  function automatic void sort_desc(input int v [4], output int s [4]);
    s = v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
        if (s[j] < s[j+1]) begin
          int t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
  endfunction

  function automatic int net_swaps(input int v [4]);
    int px [5] = '{0, 1, 0, 2, 1};
    int py [5] = '{2, 3, 1, 3, 2};
    int s [4];
    int n = 0;
    s = v;
    for (int k = 0; k < 5; k++)
      if (s[px[k]] < s[py[k]]) begin
        int t = s[px[k]]; s[px[k]] = s[py[k]]; s[py[k]] = t; n++;
      end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_swaps = 0;
      m_hold = '{0, 0, 0, 0};
    end else begin
      cyc++;
      case (m_phase)
        0: if (in_valid) begin
             m_ops = '{int'(a), int'(b), int'(c), int'(d)};
             sort_desc(m_ops, m_res);
             m_res_sw = net_swaps(m_ops);
             m_phase = 1; m_cnt = 0;
             n_accepts++;
             accept_cyc.push_back(cyc);
           end
        1: begin
             m_cnt++;
             if (m_cnt == 5) begin
               m_phase = 2; m_hold = m_res; m_swaps = m_res_sw;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_phase == 0));
    chk("out_valid", int'(out_valid), int'(m_phase == 2));
    chk("busy", int'(busy), int'(m_phase != 0));
    if (m_phase != 1) begin
      chk("ra", int'(ra), m_hold[0]);
      chk("rb", int'(rb), m_hold[1]);
      chk("rc", int'(rc), m_hold[2]);
      chk("rd", int'(rd), m_hold[3]);
`ifdef SORT4_SWAPCNT_EN
      chk("swap_cnt", int'(swap_cnt), m_swaps);
`endif
    end else begin
      // Intermediate slots must remain a permutation of the operands
      chk("cmp_sum", int'(ra) + int'(rb) + int'(rc) + int'(rd),
          m_ops[0] + m_ops[1] + m_ops[2] + m_ops[3]);
    end
  end

  task automatic set_ops(input int va, vb, vc, vd);
    a = W'(va); b = W'(vb); c = W'(vc); d = W'(vd);
  endtask

  task automatic accept_set(input int va, vb, vc, vd, input string nm);
    bit acc = 0;
    bit rs;
    @(posedge clk); #1;
    in_valid = 1'b1;
    set_ops(va, vb, vc, vd);
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk); rs = in_ready;
      @(posedge clk); #1;
      if (rs) acc = 1;
    end
    in_valid = 1'b0;
    chk({nm, "_accept"}, int'(acc), 1);
  endtask

  task automatic wait_result(input string nm, input int e0, e1, e2, e3, input int esw);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, n, 5);
    chk({nm, "_ra"}, int'(ra), e0);
    chk({nm, "_rb"}, int'(rb), e1);
    chk({nm, "_rc"}, int'(rc), e2);
    chk({nm, "_rd"}, int'(rd), e3);
    chk({nm, "_model_ra"}, m_hold[0], e0);
    chk({nm, "_model_rd"}, m_hold[3], e3);
    chk({nm, "_model_sw"}, m_swaps, esw);
`ifdef SORT4_SWAPCNT_EN
    chk({nm, "_swap_cnt"}, int'(swap_cnt), esw);
`endif
  endtask

  task automatic run_set(input int va, vb, vc, vd, input int e0, e1, e2, e3,
                         input int esw, input string nm);
    out_ready = 1'b1;
    accept_set(va, vb, vc, vd, nm);
    wait_result(nm, e0, e1, e2, e3, esw);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  initial begin
    int na0, n;
    #2;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ra", int'(ra), 0);
    chk("reset_rd", int'(rd), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_set(3, 9, 1, 7, 9, 7, 3, 1, 3, "mixed");
    run_set(0, 1, 2, 3, 3, 2, 1, 0, 4, "ascending");
    run_set(15, 10, 5, 0, 15, 10, 5, 0, 0, "sorted");
    run_set(5, 5, 5, 5, 5, 5, 5, 5, 0, "equal");

    // Backpressure with competing new operands
    out_ready = 1'b0;
    accept_set(3, 9, 1, 7, "bp");
    wait_result("bp", 9, 7, 3, 1, 3);
    in_valid = 1'b1;
    set_ops(15, 10, 5, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_in_ready", int'(in_ready), 0);
      chk("bp_hold_ra", int'(ra), 9);
      chk("bp_hold_rd", int'(rd), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_busy", int'(busy), 1);
    wait_result("bp_new", 15, 10, 5, 0, 0);
    @(posedge clk); #1;

    // Back-to-back with both handshakes held high
    na0 = n_accepts;
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_ops(0, 1, 2, 3);
    n = 0;
    while (n_accepts < na0 + 1 && n < 30) begin @(posedge clk); #1; n++; end
    set_ops(2, 14, 6, 9);
    n = 0;
    while (n_accepts < na0 + 2 && n < 30) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    chk("b2b_accepts", n_accepts - na0, 2);
    if (n_accepts >= na0 + 2)
      chk("b2b_spacing", accept_cyc[na0+1] - accept_cyc[na0], 7);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_last_ra", int'(ra), 14);
    chk("b2b_last_rd", int'(rd), 2);

    // Asynchronous reset during step 2
    accept_set(3, 9, 1, 7, "rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ra", int'(ra), 0);
    chk("rst_rb", int'(rb), 0);
    chk("rst_rc", int'(rc), 0);
    chk("rst_rd", int'(rd), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_no_valid", int'(out_valid), 0);
    end

    // Random traffic against the model
    na0 = n_accepts;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      set_ops($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("random_accepts_seen", int'(n_accepts - na0 > 20), 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
